// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and per-stage bundle widths for pipeline stage buffers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int ID_EX_DATA_W  = 106;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int EX_MEM_DATA_W = 69;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 69;

    // Control bundle bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ZERO     = 5;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one ctrl/data storage slot with load and clear
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 69,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Clear wins over load so a bubble is never overwritten in the same cycle
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr) begin
            ctrl_d = '0;
            if (CLEAR_DATA) data_d = '0;
        end else if (load) begin
            ctrl_d = ld_ctrl;
            data_d = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl = ctrl_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage register with two-entry skid buffer, flush and stall counter
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 69,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    pipe_state_e state_d, state_q;
    logic        in_ready_q, out_valid_q;
    logic        in_fire, out_fire;
    logic        main_load, main_from_skid, main_clr, skid_load, skid_clr;
    logic [CTRL_W-1:0] skid_ctrl, main_src_ctrl;
    logic [DATA_W-1:0] skid_data, main_src_data;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_src_data = main_from_skid ? skid_data : in_data;

    // Handshake flags are registered alongside the state so in_ready never sees out_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clr     (main_clr),
        .ld_ctrl (main_src_ctrl),
        .ld_data (main_src_data),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clr     (skid_clr),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf against a queue reference model
module tb_pipe_stage_buf;

    localparam int CW = 8;
    localparam int DW = 69;
    localparam int NW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;
    logic          stall_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [CW+DW-1:0] m_q[$];
    int               m_cnt = 0;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        return m_q.size() > 0;
    endfunction

    function automatic logic m_ready();
        return m_q.size() < 2;
    endfunction

    function automatic logic [CW-1:0] m_ctrl();
        logic [CW+DW-1:0] e;
        if (m_q.size() == 0) return '0;
        e = m_q[0];
        return e[CW+DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] m_data();
        logic [CW+DW-1:0] e;
        if (m_q.size() == 0) return '0;
        e = m_q[0];
        return e[DW-1:0];
    endfunction

    // Applies one cycle of inputs, clocks, and advances the model; no checking here
    task automatic drive_cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                               input logic ordy, input logic fl, input logic sc);
        logic in_f, out_f, stall;
        in_valid = iv; in_ctrl = ic; in_data = id;
        out_ready = ordy; flush = fl; stall_clr = sc;
        in_f  = iv && m_ready();
        out_f = m_valid() && ordy;
        stall = m_valid() && !ordy;
        @(posedge clk);
        #1;
        if (sc) m_cnt = 0;
        else if (stall && m_cnt < CMAX) m_cnt++;
        if (fl) m_q.delete();
        else begin
            if (out_f) void'(m_q.pop_front());
            if (in_f) m_q.push_back({ic, id});
        end
        in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        m_q.delete(); m_cnt = 0;
    endtask

    task automatic test_fill();
        drive_cycle(1'b1, 8'hA5, 69'h1234, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid got %0b want 1", out_valid); end
        checks++; if (out_ctrl !== 8'hA5) begin errors++; $display("FAIL fill_out_ctrl got %h want a5", out_ctrl); end
        checks++; if (out_data !== 69'h1234) begin errors++; $display("FAIL fill_out_data got %h want 1234", out_data); end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
            errors++; $display("FAIL fill_drain got v=%0b c=%h d=%h want empty zeros", out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_streaming();
        logic [CW-1:0] c;
        for (int i = 0; i < 10; i++) begin
            c = CW'(8'h10 + i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            drive_cycle(1'b1, c, DW'(1000 + i), 1'b1, 1'b0, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_ctrl !== c || out_data !== DW'(1000 + i)) begin
                errors++; $display("FAIL stream_out[%0d] got v=%0b c=%h d=%0d want 1 %h %0d", i, out_valid, out_ctrl, out_data, c, 1000 + i);
            end
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_skid();
        drive_cycle(1'b1, 8'h31, 69'h31, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h32, 69'h32, 1'b0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready got %0b want 0", in_ready); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL skid_cnt1 got %0d want 1", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 8'h33, 69'h33, 1'b0, 1'b0, 1'b0);
            checks++; if (out_ctrl !== 8'h31 || out_data !== 69'h31 || in_ready !== 1'b0) begin
                errors++; $display("FAIL skid_hold[%0d] got c=%h d=%h r=%0b want 31 31 0", i, out_ctrl, out_data, in_ready);
            end
            checks++; if (stall_cnt !== NW'(2 + i)) begin errors++; $display("FAIL skid_cnt[%0d] got %0d want %0d", i, stall_cnt, 2 + i); end
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h32 || in_ready !== 1'b1) begin
            errors++; $display("FAIL skid_drain1 got v=%0b c=%h r=%0b want 1 32 1", out_valid, out_ctrl, in_ready);
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL skid_drain2 got v=%0b c=%h n=%0d want 0 0 0", out_valid, out_ctrl, stall_cnt);
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 8'h41, 69'h41, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h42, 69'h42, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'hFF, 69'h1FF, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%0b c=%h r=%0b want 0 0 1", out_valid, out_ctrl, in_ready);
        end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_data got %h want 0", out_data); end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 8'h51, 69'h51, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h52, 69'h52, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_hs got v=%0b r=%0b want 0 1", out_valid, in_ready);
        end
        checks++; if (out_ctrl !== '0 || out_data !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL areset_vals got c=%h d=%h n=%0d want 0 0 0", out_ctrl, out_data, stall_cnt);
        end
        m_q.delete(); m_cnt = 0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_counter_sat();
        drive_cycle(1'b1, 8'h61, 69'h61, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_saturate got %0d want 15", stall_cnt); end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", stall_cnt); end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL cnt_restart got %0d want 1", stall_cnt); end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom, $urandom};
            drive_cycle(1'($urandom_range(0, 3) != 0), CW'($urandom), d,
                        1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0),
                        1'($urandom_range(0, 29) == 0));
            checks++; if (out_valid !== m_valid() || in_ready !== m_ready()) begin
                errors++; $display("FAIL rand_hs[%0d] got v=%0b r=%0b want %0b %0b", i, out_valid, in_ready, m_valid(), m_ready());
            end
            checks++; if (out_ctrl !== m_ctrl() || out_data !== m_data()) begin
                errors++; $display("FAIL rand_out[%0d] got c=%h d=%h want %h %h", i, out_ctrl, out_data, m_ctrl(), m_data());
            end
            checks++; if (stall_cnt !== NW'(m_cnt)) begin
                errors++; $display("FAIL rand_cnt[%0d] got %0d want %0d", i, stall_cnt, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_async_reset();
        test_counter_sat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
